// File: rtl/uart_rx.sv
// uart_rx -- memory-mapped 8N1 UART receiver with a byte FIFO.
//
// Deserialises frames from the asynchronous rx pin and buffers the received
// bytes in a FIFO_DEPTH-entry FIFO. A small register file is exposed on the
// CPU data bus, and an interrupt is raised while data is waiting.
//
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   addr           CPU address; only addr[3:2] selects a register
//   write_data     CPU store data
//   write_enable   store strobe (already qualified by region decode)
//   read_enable    load strobe (already qualified by region decode)
//   read_data      combinational register read data for addr
//   uart_rx_valid  mirrors read_enable
//   rx             serial input, idle high, asynchronous to clk
//   rx_interrupt   irq_en && FIFO not empty
//
// Register map (addr[3:2]):
//   0 RX_DATA  RO   [7:0] FIFO head (0 when empty); a read pops one entry
//   1 STATUS        [0] avail, [1] full, [2] overrun W1C, [3] frame_err W1C,
//                   [15:8] count
//   2 CTRL     RW   [0] irq_en
//   3 -             reads 0, writes ignored
module uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic        write_enable,
    input  logic        read_enable,
    output logic [31:0] read_data,
    output logic        uart_rx_valid,
    input  logic        rx,
    output logic        rx_interrupt
);

    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]  HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [FCNT_W-1:0] DEPTH_C  = FCNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t state, state_nxt;

    logic             rx_meta, rx_s;
    logic [CNT_W-1:0] tick;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;

    // FSM strobes
    logic tick_clr, shift_en, push_req, frame_set;

    // FIFO
    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [FCNT_W-1:0] count;
    logic              full, empty, pop, do_push, ovr_set;

    // Status / control
    logic       overrun, frame_err, irq_en;
    logic [1:0] sel;
    logic       wr_status, wr_ctrl;
    logic [7:0] count8;

    logic unused_bits;
    assign unused_bits = ^{addr[31:4], addr[1:0], write_data[31:4], write_data[1]};

    // ---------------------------------------------------------------
    // Synchroniser: resets to idle-high so reset never looks like a start bit
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // ---------------------------------------------------------------
    // Receive FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tick_clr  = 1'b0;
        shift_en  = 1'b0;
        push_req  = 1'b0;
        frame_set = 1'b0;
        case (state)
            IDLE: begin
                tick_clr = 1'b1;
                if (!rx_s) state_nxt = START;
            end
            START: begin
                // Half a bit in: a line that is high again was only a glitch.
                if (tick == HALF_END) begin
                    tick_clr  = 1'b1;
                    state_nxt = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick == BIT_END) begin
                    tick_clr = 1'b1;
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7) state_nxt = STOP;
                end
            end
            STOP: begin
                // Return to IDLE mid-stop-bit so a back-to-back start edge is seen.
                if (tick == BIT_END) begin
                    tick_clr  = 1'b1;
                    state_nxt = IDLE;
                    if (rx_s) push_req  = 1'b1;
                    else      frame_set = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            tick <= tick_clr ? '0 : tick + 1'b1;
            if (state == IDLE) bit_idx <= '0;
            if (shift_en) begin
                shreg   <= {rx_s, shreg[7:1]};   // LSB arrives first
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------
    // Bus decode
    // ---------------------------------------------------------------
    assign sel       = addr[3:2];
    assign wr_status = write_enable && (sel == 2'd1);
    assign wr_ctrl   = write_enable && (sel == 2'd2);

    // ---------------------------------------------------------------
    // FIFO
    // ---------------------------------------------------------------
    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    assign pop   = read_enable && (sel == 2'd0) && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push_req && (!full || pop);
    assign ovr_set = push_req && full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= shreg;
    end

    // ---------------------------------------------------------------
    // Sticky flags (set beats W1C) and control
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            irq_en    <= 1'b0;
        end else begin
            if (ovr_set)                         overrun <= 1'b1;
            else if (wr_status && write_data[2]) overrun <= 1'b0;

            if (frame_set)                       frame_err <= 1'b1;
            else if (wr_status && write_data[3]) frame_err <= 1'b0;

            if (wr_ctrl) irq_en <= write_data[0];
        end
    end

    // ---------------------------------------------------------------
    // Read mux and outputs
    // ---------------------------------------------------------------
    assign count8 = 8'(count);

    always_comb begin
        read_data = '0;
        case (sel)
            2'd0: if (!empty) read_data[7:0] = mem[rd_ptr];
            2'd1: begin
                read_data[0]    = !empty;
                read_data[1]    = full;
                read_data[2]    = overrun;
                read_data[3]    = frame_err;
                read_data[15:8] = count8;
            end
            2'd2: read_data[0] = irq_en;
            default: read_data = '0;
        endcase
    end

    assign uart_rx_valid = read_enable;
    assign rx_interrupt  = irq_en && !empty;

endmodule
